// File: rtl/mult_pkg.sv
// Shared definitions for the sequential carry-save multiplier.
//   - FSM state encoding (IDLE, ACCUM, RESOLVE, DONE)
//   - cnt_w(width):  row-counter width for a given operand width
//   - prod_w(width): product width (2*width)
package mult_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle    = 2'd0;
   localparam state_t StAccum   = 2'd1;
   localparam state_t StResolve = 2'd2;
   localparam state_t StDone    = 2'd3;

   // A one-bit counter still needs one bit when width is a power of two of 1.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   function automatic int unsigned prod_w(input int unsigned width);
      return 2 * width;
   endfunction

endpackage

// File: rtl/csa_row.sv
// N-bit 3:2 compressor built from independent per-bit full adders.
// Ports:
//   sum, carry, row  in   N  three operands to compress
//   sum_new          out  N  bitwise sum
//   carry_new        out  N  bitwise carry, unshifted (bit i has weight 2^(i+1))
module csa_row #(
   parameter int unsigned N = 16
) (
   input  logic [N-1:0] sum,
   input  logic [N-1:0] carry,
   input  logic [N-1:0] row,
   output logic [N-1:0] sum_new,
   output logic [N-1:0] carry_new
);

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign sum_new[i]   = sum[i] ^ carry[i] ^ row[i];
      assign carry_new[i] = (sum[i] & carry[i]) | (sum[i] & row[i]) | (carry[i] & row[i]);
   end

endmodule

// File: rtl/seq_csa_mult.sv
// Sequential WIDTH x WIDTH multiplier. One partial-product row per cycle is folded into a
// carry-save accumulator; a single carry-propagate add resolves the product at the end.
// Latency from the accepting edge to out_valid is WIDTH+1 cycles.
//
// Optional feature: define SEQ_MULT_SIGNED_EN to honour is_signed (two's-complement
// multiply). Without it is_signed is ignored and every operation is unsigned.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready only in IDLE, low during reset)
//   m, q, is_signed      multiplicand, multiplier, signed request (sampled at acceptance)
//   out_valid, out_ready product handshake
//   p                    2*WIDTH product, held from DONE entry until the next RESOLVE
//   busy                 high in every state except IDLE
module seq_csa_mult
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         m,
   input  logic [WIDTH-1:0]         q,
   input  logic                     is_signed,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [prod_w(WIDTH)-1:0] p,
   output logic                     busy
);

   localparam int unsigned PW    = prod_w(WIDTH);
   localparam int unsigned CNT_W = cnt_w(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] m_q, q_q;
   logic [PW-1:0]    sum_q, sum_d;
   logic [PW-1:0]    carry_q, carry_d;
   logic [PW-1:0]    p_q, p_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [PW-1:0]    row;
   logic [PW-1:0]    csa_sum, csa_carry;
   logic             neg_row;
   logic             accept;
   logic             last_row;
   logic             unused_carry_msb;

   assign in_ready  = (state_q == StIdle) & ~rst;
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign p         = p_q;

   assign accept   = in_valid & in_ready;
   assign last_row = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
   logic          sgn_q;
   logic [PW-1:0] m_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sgn_q <= 1'b0;
      end else if (accept) begin
         sgn_q <= is_signed;
      end
   end

   // Signed: rows are sign-extended; the top row carries negative weight, so it is inverted
   // here and the +1 of the two's-complement negation enters through the carry LSB.
   always_comb begin
      m_ext   = {{WIDTH{sgn_q & m_q[WIDTH-1]}}, m_q};
      neg_row = sgn_q & last_row;
      row     = (m_ext & {PW{q_q[cnt_q]}}) << cnt_q;
      if (neg_row) begin
         row = ~row;
      end
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign neg_row          = 1'b0;
   assign row              = ({{WIDTH{1'b0}}, m_q} & {PW{q_q[cnt_q]}}) << cnt_q;
`endif

   csa_row #(
      .N (PW)
   ) u_csa_row (
      .sum       (sum_q),
      .carry     (carry_q),
      .row       (row),
      .sum_new   (csa_sum),
      .carry_new (csa_carry)
   );

   // The carry MSB would land at bit 2*WIDTH after the shift and falls outside the modulus.
   assign unused_carry_msb = csa_carry[PW-1];

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StAccum;
               sum_d   = '0;
               carry_d = '0;
               cnt_d   = '0;
            end
         end
         StAccum: begin
            sum_d   = csa_sum;
            carry_d = {csa_carry[PW-2:0], neg_row};
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_row) begin
               state_d = StResolve;
            end
         end
         StResolve: begin
            p_d     = sum_q + carry_q;
            state_d = StDone;
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         m_q     <= '0;
         q_q     <= '0;
         sum_q   <= '0;
         carry_q <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         if (accept) begin
            m_q <= m;
            q_q <= q;
         end
      end
   end

endmodule
